instr_encoder_loader: RTL and testbench

//  Inverse of the control decode path: takes symbolic instructions (op ID + register/immediate fields) via valid/ready,

---
 rtl/instr_pkg.sv | 88 ++++++++
 rtl/instr_fifo.sv | 73 +++++++
 rtl/instr_encoder_loader.sv | 189 ++++++++++++++++++
 tb/tb_instr_encoder_loader.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_pkg.sv
// Shared definitions for the instruction encoder/loader and the control-unit
// benches: symbolic op IDs, MIPS opcode/funct fields and loader FSM states.
package instr_pkg;

   typedef enum logic [4:0] {
      OP_ADD   = 5'd0,
      OP_ADDU  = 5'd1,
      OP_ADDI  = 5'd2,
      OP_ADDIU = 5'd3,
      OP_SUB   = 5'd4,
      OP_SUBU  = 5'd5,
      OP_AND   = 5'd6,
      OP_ANDI  = 5'd7,
      OP_NOR   = 5'd8,
      OP_OR    = 5'd9,
      OP_ORI   = 5'd10,
      OP_XOR   = 5'd11,
      OP_XORI  = 5'd12,
      OP_SLL   = 5'd13,
      OP_SLLV  = 5'd14,
      OP_SRA   = 5'd15,
      OP_SRAV  = 5'd16,
      OP_SRL   = 5'd17,
      OP_SRLV  = 5'd18,
      OP_BEQ   = 5'd19,
      OP_BNE   = 5'd20,
      OP_SLT   = 5'd21,
      OP_LW    = 5'd22,
      OP_SW    = 5'd23,
      OP_J     = 5'd24,
      OP_JAL   = 5'd25,
      OP_JR    = 5'd26
   } op_id_e;

   // primary opcodes
   localparam logic [5:0] OPC_RTYPE = 6'h00;
   localparam logic [5:0] OPC_J     = 6'h02;
   localparam logic [5:0] OPC_JAL   = 6'h03;
   localparam logic [5:0] OPC_BEQ   = 6'h04;
   localparam logic [5:0] OPC_BNE   = 6'h05;
   localparam logic [5:0] OPC_ADDI  = 6'h08;
   localparam logic [5:0] OPC_ADDIU = 6'h09;
   localparam logic [5:0] OPC_ANDI  = 6'h0C;
   localparam logic [5:0] OPC_ORI   = 6'h0D;
   localparam logic [5:0] OPC_XORI  = 6'h0E;
   localparam logic [5:0] OPC_LW    = 6'h23;
   localparam logic [5:0] OPC_SW    = 6'h2B;

   // R-type function codes
   localparam logic [5:0] FN_SLL  = 6'h00;
   localparam logic [5:0] FN_SRL  = 6'h02;
   localparam logic [5:0] FN_SRA  = 6'h03;
   localparam logic [5:0] FN_SLLV = 6'h04;
   localparam logic [5:0] FN_SRLV = 6'h06;
   localparam logic [5:0] FN_SRAV = 6'h07;
   localparam logic [5:0] FN_JR   = 6'h08;
   localparam logic [5:0] FN_ADD  = 6'h20;
   localparam logic [5:0] FN_ADDU = 6'h21;
   localparam logic [5:0] FN_SUB  = 6'h22;
   localparam logic [5:0] FN_SUBU = 6'h23;
   localparam logic [5:0] FN_AND  = 6'h24;
   localparam logic [5:0] FN_OR   = 6'h25;
   localparam logic [5:0] FN_XOR  = 6'h26;
   localparam logic [5:0] FN_NOR  = 6'h27;
   localparam logic [5:0] FN_SLT  = 6'h2A;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } ld_state_e;

   function automatic logic [31:0] pack_r(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [4:0] sh,
                                          input logic [5:0] fn);
      return {OPC_RTYPE, rs, rt, rd, sh, fn};
   endfunction

   function automatic logic [31:0] pack_i(input logic [5:0] opc, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
      return {opc, rs, rt, imm};
   endfunction

   function automatic logic [31:0] pack_j(input logic [5:0] opc, input logic [25:0] tgt);
      return {opc, tgt};
   endfunction

endpackage

// File: rtl/instr_fifo.sv
// Small synchronous FIFO holding encoded words between the encoder and the
// instruction-memory write port. Head word is visible combinationally.
module instr_fifo
   import instr_pkg::*;
#(
   parameter int DEPTH  = 4,
   parameter int DATA_W = 32
)
(
   input  logic              clk,
   input  logic              reset,
   input  logic              push,
   input  logic [DATA_W-1:0] push_data,
   input  logic              pop,
   output logic [DATA_W-1:0] pop_data,
   output logic              full,
   output logic              empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);

   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]    count_q, count_d;
   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] mem_d [DEPTH];
   logic              do_push, do_pop;

   assign full     = (count_q == DEPTH_C);
   assign empty    = (count_q == '0);
   assign pop_data = mem_q[rd_ptr_q];
   assign do_push  = push && !full;
   assign do_pop   = pop && !empty;

   // pointer/occupancy update; pointers wrap because DEPTH is a power of two
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      mem_d    = mem_q;
      if (do_push) begin
         mem_d[wr_ptr_q] = push_data;
         wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // storage and pointer registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         mem_q    <= mem_d;
      end
   end

endmodule

// File: rtl/instr_encoder_loader.sv
// Encodes symbolic instructions into MIPS words and streams them into
// instruction memory at consecutive word addresses.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   ST_IDLE  | waiting for start; no requests accepted
//   ST_RUN   | accepting requests, FIFO drains to memory
//   ST_DRAIN | no new requests; leave (pulse done) once the FIFO is empty
module instr_encoder_loader
   import instr_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int ADDR_W     = 32
)
(
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] start_addr,
   input  logic              finish,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [4:0]        in_opid,
   input  logic [4:0]        in_rs,
   input  logic [4:0]        in_rt,
   input  logic [4:0]        in_rd,
   input  logic [4:0]        in_shamt,
   input  logic [15:0]       in_imm,
   input  logic [25:0]       in_target,
   input  logic              mem_busy,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic              done,
   output logic              illegal_err,
   output logic [15:0]       word_count
);

   localparam logic [ADDR_W-1:0] ADDR_INC  = ADDR_W'(4);
   localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(3);

   ld_state_e         state_q, state_d;
   logic [ADDR_W-1:0] ptr_q, ptr_d;
   logic              imem_we_q, imem_we_d;
   logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
   logic [31:0]       imem_wdata_q, imem_wdata_d;
   logic              done_q, done_d;
   logic              illegal_err_q, illegal_err_d;
   logic [15:0]       word_count_q, word_count_d;

   logic [31:0]       enc_word;
   logic              enc_legal;
   logic              accept, push, pop, start_go;
   logic              fifo_full, fifo_empty;
   logic [31:0]       fifo_rd_data;

   assign in_ready = (state_q == ST_RUN) && !fifo_full;
   assign accept   = in_valid && in_ready;
   assign push     = accept && enc_legal;
   assign pop      = !fifo_empty && !mem_busy;
   assign start_go = (state_q == ST_IDLE) && start;

   assign imem_we     = imem_we_q;
   assign imem_addr   = imem_addr_q;
   assign imem_wdata  = imem_wdata_q;
   assign done        = done_q;
   assign illegal_err = illegal_err_q;
   assign word_count  = word_count_q;

   instr_fifo #(
      .DEPTH  (FIFO_DEPTH),
      .DATA_W (32)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (push),
      .push_data (enc_word),
      .pop       (pop),
      .pop_data  (fifo_rd_data),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   // op ID -> MIPS word; fields an op does not use are forced to zero
   always_comb begin
      enc_word  = '0;
      enc_legal = 1'b1;
      case (in_opid)
         OP_ADD:   enc_word = pack_r(in_rs, in_rt, in_rd, 5'd0, FN_ADD);
         OP_ADDU:  enc_word = pack_r(in_rs, in_rt, in_rd, 5'd0, FN_ADDU);
         OP_SUB:   enc_word = pack_r(in_rs, in_rt, in_rd, 5'd0, FN_SUB);
         OP_SUBU:  enc_word = pack_r(in_rs, in_rt, in_rd, 5'd0, FN_SUBU);
         OP_AND:   enc_word = pack_r(in_rs, in_rt, in_rd, 5'd0, FN_AND);
         OP_OR:    enc_word = pack_r(in_rs, in_rt, in_rd, 5'd0, FN_OR);
         OP_XOR:   enc_word = pack_r(in_rs, in_rt, in_rd, 5'd0, FN_XOR);
         OP_NOR:   enc_word = pack_r(in_rs, in_rt, in_rd, 5'd0, FN_NOR);
         OP_SLT:   enc_word = pack_r(in_rs, in_rt, in_rd, 5'd0, FN_SLT);
         OP_SLLV:  enc_word = pack_r(in_rs, in_rt, in_rd, 5'd0, FN_SLLV);
         OP_SRLV:  enc_word = pack_r(in_rs, in_rt, in_rd, 5'd0, FN_SRLV);
         OP_SRAV:  enc_word = pack_r(in_rs, in_rt, in_rd, 5'd0, FN_SRAV);
         OP_SLL:   enc_word = pack_r(5'd0, in_rt, in_rd, in_shamt, FN_SLL);
         OP_SRL:   enc_word = pack_r(5'd0, in_rt, in_rd, in_shamt, FN_SRL);
         OP_SRA:   enc_word = pack_r(5'd0, in_rt, in_rd, in_shamt, FN_SRA);
         OP_JR:    enc_word = pack_r(in_rs, 5'd0, 5'd0, 5'd0, FN_JR);
         OP_ADDI:  enc_word = pack_i(OPC_ADDI, in_rs, in_rt, in_imm);
         OP_ADDIU: enc_word = pack_i(OPC_ADDIU, in_rs, in_rt, in_imm);
         OP_ANDI:  enc_word = pack_i(OPC_ANDI, in_rs, in_rt, in_imm);
         OP_ORI:   enc_word = pack_i(OPC_ORI, in_rs, in_rt, in_imm);
         OP_XORI:  enc_word = pack_i(OPC_XORI, in_rs, in_rt, in_imm);
         OP_BEQ:   enc_word = pack_i(OPC_BEQ, in_rs, in_rt, in_imm);
         OP_BNE:   enc_word = pack_i(OPC_BNE, in_rs, in_rt, in_imm);
         OP_LW:    enc_word = pack_i(OPC_LW, in_rs, in_rt, in_imm);
         OP_SW:    enc_word = pack_i(OPC_SW, in_rs, in_rt, in_imm);
         OP_J:     enc_word = pack_j(OPC_J, in_target);
         OP_JAL:   enc_word = pack_j(OPC_JAL, in_target);
         default:  enc_legal = 1'b0;
      endcase
   end

   // sequencing FSM plus write side; the write side runs whenever data is
   // queued, independent of state, so RUN and DRAIN both drain the FIFO
   always_comb begin
      state_d       = state_q;
      done_d        = 1'b0;
      ptr_d         = ptr_q;
      imem_we_d     = 1'b0;
      imem_addr_d   = imem_addr_q;
      imem_wdata_d  = imem_wdata_q;
      illegal_err_d = illegal_err_q;
      word_count_d  = word_count_q;

      case (state_q)
         ST_IDLE:  if (start) state_d = ST_RUN;
         ST_RUN:   if (finish) state_d = ST_DRAIN;
         ST_DRAIN: begin
            // the last write is already registered once the FIFO is empty
            if (fifo_empty) begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
            end
         end
         default:  state_d = ST_IDLE;
      endcase

      if (pop) begin
         imem_we_d    = 1'b1;
         imem_addr_d  = ptr_q;
         imem_wdata_d = fifo_rd_data;
         ptr_d        = ptr_q + ADDR_INC;
         if (word_count_q != 16'hFFFF) begin
            word_count_d = word_count_q + 16'd1;
         end
      end

      if (accept && !enc_legal) begin
         illegal_err_d = 1'b1;
      end

      if (start_go) begin
         ptr_d         = start_addr & WORD_MASK;
         word_count_d  = '0;
         illegal_err_d = 1'b0;
      end
   end

   // state and registered outputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= ST_IDLE;
         ptr_q         <= '0;
         imem_we_q     <= 1'b0;
         imem_addr_q   <= '0;
         imem_wdata_q  <= '0;
         done_q        <= 1'b0;
         illegal_err_q <= 1'b0;
         word_count_q  <= '0;
      end else begin
         state_q       <= state_d;
         ptr_q         <= ptr_d;
         imem_we_q     <= imem_we_d;
         imem_addr_q   <= imem_addr_d;
         imem_wdata_q  <= imem_wdata_d;
         done_q        <= done_d;
         illegal_err_q <= illegal_err_d;
         word_count_q  <= word_count_d;
      end
   end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Bench for instr_encoder_loader: directed vectors plus randomized programs
// checked against a table-driven encoder and an address/word scoreboard.
module tb_instr_encoder_loader;

   logic        clk = 1'b0;
   logic        reset;
   logic        start, finish;
   logic [31:0] start_addr;
   logic        in_valid, in_ready;
   logic [4:0]  in_opid, in_rs, in_rt, in_rd, in_shamt;
   logic [15:0] in_imm;
   logic [25:0] in_target;
   logic        mem_busy;
   logic        imem_we;
   logic [31:0] imem_addr, imem_wdata;
   logic        done, illegal_err;
   logic [15:0] word_count;

   instr_encoder_loader dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .start_addr  (start_addr),
      .finish      (finish),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_opid     (in_opid),
      .in_rs       (in_rs),
      .in_rt       (in_rt),
      .in_rd       (in_rd),
      .in_shamt    (in_shamt),
      .in_imm      (in_imm),
      .in_target   (in_target),
      .mem_busy    (mem_busy),
      .imem_we     (imem_we),
      .imem_addr   (imem_addr),
      .imem_wdata  (imem_wdata),
      .done        (done),
      .illegal_err (illegal_err),
      .word_count  (word_count)
   );

   always #5 clk = ~clk;

   // kind: 0 R-type, 1 R-type shift by shamt, 2 jr, 3 I-type, 4 J-type
   int kind_tab [27] = '{0, 0, 3, 3, 0, 0, 0, 3, 0, 0, 3, 0, 3, 1, 0, 1, 0, 1, 0, 3, 3, 0, 3, 3, 4, 4, 2};
   // funct for kinds 0..2, primary opcode for kinds 3..4
   int code_tab [27] = '{'h20, 'h21, 'h08, 'h09, 'h22, 'h23, 'h24, 'h0C, 'h27, 'h25, 'h0D, 'h26, 'h0E, 'h00,
                         'h04, 'h03, 'h07, 'h02, 'h06, 'h04, 'h05, 'h2A, 'h23, 'h2B, 'h02, 'h03, 'h08};

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [31:0] exp_q [$];
   logic [31:0] exp_ptr;
   int          exp_count;
   bit          exp_illegal;
   bit          rand_busy, busy_force;
   bit          use_lit;
   logic [31:0] lit;
   bit          prev_we, cur_we;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] encode(input int op, input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [4:0] sh,
                                          input logic [15:0] imm, input logic [25:0] tgt);
      logic [31:0] c;
      c = 32'(code_tab[op]);
      case (kind_tab[op])
         0:       return (32'(rs) << 21) | (32'(rt) << 16) | (32'(rd) << 11) | c;
         1:       return (32'(rt) << 16) | (32'(rd) << 11) | (32'(sh) << 6) | c;
         2:       return (32'(rs) << 21) | c;
         3:       return (c << 26) | (32'(rs) << 21) | (32'(rt) << 16) | 32'(imm);
         default: return (c << 26) | 32'(tgt);
      endcase
   endfunction

   // advance one clock, then score any write that edge produced
   task automatic tick();
      logic [31:0] w;
      @(posedge clk);
      #1;
      prev_we = cur_we;
      cur_we  = (imem_we === 1'b1);
      if (cur_we) begin
         if (exp_q.size() == 0) begin
            check("unexpected_write", 1, 0);
         end else begin
            w = exp_q.pop_front();
            check("wdata", imem_wdata, w);
            check("addr", imem_addr, exp_ptr);
            exp_ptr   = exp_ptr + 32'd4;
            exp_count = exp_count + 1;
            check("word_count", word_count, exp_count);
         end
      end
      mem_busy = rand_busy ? ($urandom_range(0, 3) == 0) : busy_force;
   endtask

   task automatic set_busy(input bit b);
      busy_force = b;
      mem_busy   = b;
   endtask

   task automatic present(input logic [4:0] op, input logic [4:0] rs, input logic [4:0] rt,
                          input logic [4:0] rd, input logic [4:0] sh, input logic [15:0] imm,
                          input logic [25:0] tgt);
      in_opid   = op;
      in_rs     = rs;
      in_rt     = rt;
      in_rd     = rd;
      in_shamt  = sh;
      in_imm    = imm;
      in_target = tgt;
      in_valid  = 1'b1;
   endtask

   task automatic accept_wait();
      bit ok;
      bit acc;
      ok = 0;
      for (int i = 0; i < 300 && !ok; i++) begin
         acc = in_ready;
         tick();
         if (acc) begin
            ok = 1;
            if (in_opid <= 5'd26) begin
               exp_q.push_back(use_lit ? lit : encode(int'(in_opid), in_rs, in_rt, in_rd, in_shamt,
                                                      in_imm, in_target));
            end else begin
               exp_illegal = 1;
            end
         end
      end
      in_valid = 1'b0;
      use_lit  = 0;
      if (!ok) check("accept_timeout", 0, 1);
   endtask

   task automatic send_lit(input logic [31:0] w, input logic [4:0] op, input logic [4:0] rs,
                           input logic [4:0] rt, input logic [4:0] rd, input logic [4:0] sh,
                           input logic [15:0] imm, input logic [25:0] tgt);
      present(op, rs, rt, rd, sh, imm, tgt);
      use_lit = 1;
      lit     = w;
      accept_wait();
   endtask

   task automatic send_rand();
      logic [4:0] op;
      if ($urandom_range(0, 9) == 0) op = 5'($urandom_range(27, 31));
      else op = 5'($urandom_range(0, 26));
      present(op, 5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 16'($urandom), 26'($urandom));
      accept_wait();
   endtask

   task automatic do_start(input logic [31:0] a);
      start      = 1'b1;
      start_addr = a;
      tick();
      start       = 1'b0;
      exp_ptr     = a & 32'hFFFF_FFFC;
      exp_count   = 0;
      exp_illegal = 0;
   endtask

   task automatic wait_done(input string tag, input bit expect_tail);
      bit seen;
      seen = 0;
      for (int i = 0; i < 400 && !seen; i++) begin
         tick();
         if (done === 1'b1) seen = 1;
      end
      check({tag, "_done_seen"}, seen, 1);
      if (seen) begin
         check({tag, "_queue_empty"}, exp_q.size(), 0);
         check({tag, "_count"}, word_count, exp_count);
         check({tag, "_illegal"}, illegal_err, exp_illegal);
         if (expect_tail) check({tag, "_done_after_last_we"}, prev_we, 1);
         tick();
         check({tag, "_done_one_cycle"}, done, 0);
      end
   endtask

   task automatic do_finish(input string tag, input bit expect_tail);
      finish = 1'b1;
      tick();
      finish = 1'b0;
      wait_done(tag, expect_tail);
   endtask

   initial begin
      reset = 1'b1;
      start = 1'b0;
      finish = 1'b0;
      start_addr = '0;
      in_valid = 1'b0;
      present(5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 16'd0, 26'd0);
      in_valid = 1'b0;
      rand_busy = 0;
      use_lit = 0;
      set_busy(0);
      exp_ptr = '0;
      exp_count = 0;
      exp_illegal = 0;
      prev_we = 0;
      cur_we = 0;
      tick();
      tick();
      check("rst_we", imem_we, 0);
      check("rst_addr", imem_addr, 0);
      check("rst_wdata", imem_wdata, 0);
      check("rst_done", done, 0);
      check("rst_illegal", illegal_err, 0);
      check("rst_count", word_count, 0);
      check("rst_ready", in_ready, 0);
      reset = 1'b0;
      tick();

      // finish while idle does nothing
      finish = 1'b1;
      tick();
      finish = 1'b0;
      tick();
      check("idle_finish_done", done, 0);
      check("idle_finish_ready", in_ready, 0);

      // T1: single add; a second start while running is ignored
      do_start(32'h0);
      check("t1_ready", in_ready, 1);
      start = 1'b1;
      start_addr = 32'h500;
      tick();
      start = 1'b0;
      send_lit(32'h0022_1820, 5'd0, 5'd1, 5'd2, 5'd3, 5'd0, 16'd0, 26'd0);
      do_finish("t1", 1);

      // T2: start and finish together in IDLE -> start wins
      start = 1'b1;
      finish = 1'b1;
      start_addr = 32'h0;
      tick();
      start = 1'b0;
      finish = 1'b0;
      exp_ptr = 32'h0;
      exp_count = 0;
      exp_illegal = 0;
      check("t2_still_run", in_ready, 1);
      send_lit(32'h2008_0005, 5'd2, 5'd0, 5'd8, 5'd0, 5'd0, 16'd5, 26'd0);
      send_lit(32'h0001_1100, 5'd13, 5'd0, 5'd1, 5'd2, 5'd4, 16'd0, 26'd0);
      send_lit(32'h8FA4_0008, 5'd22, 5'd29, 5'd4, 5'd0, 5'd0, 16'd8, 26'd0);
      do_finish("t2", 1);

      // T3: jumps; stray rt/rd/shamt must not reach the jr word
      do_start(32'h100);
      send_lit(32'h0800_0040, 5'd24, 5'd0, 5'd0, 5'd0, 5'd0, 16'd0, 26'h40);
      send_lit(32'h03E0_0008, 5'd26, 5'd31, 5'd5, 5'd7, 5'd9, 16'hABCD, 26'h3FF);
      do_finish("t3", 1);

      // T4: back-pressure with a full FIFO
      do_start(32'h40);
      set_busy(1);
      for (int i = 0; i < 4; i++) begin
         present(5'($urandom_range(0, 26)), 5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
                 16'($urandom), 26'($urandom));
         accept_wait();
      end
      check("t4_full_ready", in_ready, 0);
      present(5'd9, 5'd3, 5'd4, 5'd5, 5'd0, 16'd0, 26'd0);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("t4_hold_ready", in_ready, 0);
         check("t4_hold_we", imem_we, 0);
      end
      set_busy(0);
      accept_wait();
      do_finish("t4", 1);

      // T5: unknown op ID between two legal requests
      do_start(32'h200);
      send_lit(32'h0022_1820, 5'd0, 5'd1, 5'd2, 5'd3, 5'd0, 16'd0, 26'd0);
      present(5'd31, 5'd1, 5'd1, 5'd1, 5'd1, 16'd1, 26'd1);
      accept_wait();
      check("t5_illegal", illegal_err, 1);
      send_lit(encode(4, 5'd7, 5'd8, 5'd9, 5'd0, 16'd0, 26'd0), 5'd4, 5'd7, 5'd8, 5'd9, 5'd3,
               16'd0, 26'd0);
      do_finish("t5", 1);
      do_start(32'h0);
      check("t5_illegal_cleared", illegal_err, 0);
      do_finish("t5b", 0);

      // T6: finish with 3 queued, then address wrap
      do_start(32'h0);
      set_busy(1);
      for (int i = 0; i < 3; i++) send_rand();
      finish = 1'b1;
      tick();
      finish = 1'b0;
      set_busy(0);
      wait_done("t6", 1);
      do_start(32'hFFFF_FFFC);
      send_lit(32'h0022_1820, 5'd0, 5'd1, 5'd2, 5'd3, 5'd0, 16'd0, 26'd0);
      send_lit(32'h0800_0040, 5'd24, 5'd0, 5'd0, 5'd0, 5'd0, 16'd0, 26'h40);
      do_finish("t6_wrap", 1);

      // randomized programs with random memory stalls
      for (int r = 0; r < 4; r++) begin
         rand_busy = 1;
         do_start($urandom);
         for (int k = 0; k < 25; k++) begin
            send_rand();
            if ($urandom_range(0, 3) == 0) tick();
         end
         do_finish("rand", 0);
         rand_busy = 0;
         set_busy(0);
      end

      // T7: reset with two words queued
      do_start(32'h80);
      send_lit(32'h0022_1820, 5'd0, 5'd1, 5'd2, 5'd3, 5'd0, 16'd0, 26'd0);
      tick();
      tick();
      check("t7_pre_count", word_count, 1);
      set_busy(1);
      send_rand();
      send_rand();
      #3;
      reset = 1'b1;
      #1;
      check("t7_we", imem_we, 0);
      check("t7_addr", imem_addr, 0);
      check("t7_wdata", imem_wdata, 0);
      check("t7_count", word_count, 0);
      check("t7_done", done, 0);
      check("t7_ready", in_ready, 0);
      exp_q.delete();
      set_busy(0);
      tick();
      tick();
      reset = 1'b0;
      for (int i = 0; i < 6; i++) tick();
      check("t7_after_we", imem_we, 0);
      check("t7_after_ready", in_ready, 0);
      check("t7_after_count", word_count, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
